// File: rtl/seq_mult_nb_pkg.sv
// seq_mult_nb_pkg: shared definitions for the sequential shift-add multiplier.
//   state_t  : FSM state encoding (IDLE/BUSY/DONE)
//   MAX_W    : widest vector the helper function handles (product <= 64 bits)
//   f_cneg   : conditional two's-complement negate, used both to take operand
//              magnitudes and to apply the product sign
package seq_mult_nb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MAX_W = 64;

    // neg=1 returns -v, otherwise v. Callers zero-extend into MAX_W bits and
    // truncate the result back to their own width; the low bits of a two's
    // complement negate do not depend on the extension.
    function automatic logic [MAX_W-1:0] f_cneg(input logic [MAX_W-1:0] v,
                                                input logic             neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/seq_mult_nb_add.sv
// add_nb: WIDTH-bit ripple-carry adder built from full adders.
//   i_a, i_b : addends
//   i_cin    : carry in
//   o_sum    : WIDTH-bit sum
//   o_cout   : carry out of the top bit
module add_nb #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
        assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/seq_mult_nb.sv
// seq_mult_nb: sequential shift-add multiplier, one multiplier bit per clock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b, sgn           : operands; sgn=1 means two's complement
//   out_valid/out_ready : product handshake (valid only in DONE)
//   prod                : 2*WIDTH-bit product, held until taken
// Operands are converted to magnitudes on accept so the datapath is purely
// unsigned; the sign is reapplied when the final product is written.
module seq_mult_nb
    import seq_mult_nb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod
);

    state_t               r_state, w_state_nxt;
    logic [WIDTH-1:0]     r_mcand, r_mplier;
    logic [2*WIDTH-1:0]   r_acc, r_prod;
    logic [CNT_W-1:0]     r_count;
    logic                 r_neg;

    logic [WIDTH-1:0]     w_mag_a, w_mag_b, w_addend, w_sum;
    logic                 w_cout, w_last;
    logic [2*WIDTH-1:0]   w_acc_nxt, w_prod_nxt;

    // -2^(W-1) negates to itself, which read unsigned is exactly 2^(W-1).
    assign w_mag_a = WIDTH'(f_cneg(MAX_W'(a), sgn & a[WIDTH-1]));
    assign w_mag_b = WIDTH'(f_cneg(MAX_W'(b), sgn & b[WIDTH-1]));

    assign w_addend = r_mplier[0] ? r_mcand : '0;

    add_nb #(.WIDTH(WIDTH)) u_add (
        .i_a    (r_acc[2*WIDTH-1:WIDTH]),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // {carry, upper sum, lower half} shifted right one place: the carry
    // becomes the new MSB so no partial-sum bit is lost.
    assign w_acc_nxt  = {w_cout, w_sum, r_acc[WIDTH-1:1]};
    assign w_prod_nxt = (2*WIDTH)'(f_cneg(MAX_W'(w_acc_nxt), r_neg));
    assign w_last     = (r_count == CNT_W'(WIDTH - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand latch, shift-add step, counter, product register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_prod   <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= w_mag_a;
                        r_mplier <= w_mag_b;
                        r_neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                ST_BUSY: begin
                    r_acc    <= w_acc_nxt;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (w_last) r_prod <= w_prod_nxt;
                end
                default: ;
            endcase
        end
    end

    assign prod = r_prod;

endmodule

// File: tb/tb_seq_mult_nb.sv
// Bench for seq_mult_nb: a WIDTH=4 instance driven with directed vectors and
// a WIDTH=8 instance driven with random traffic. A transaction-level model
// (pending product + cycles remaining) predicts the handshakes and product.
module tb_seq_mult_nb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv4 = 0, ir4, ov4, or4 = 0, sgn4 = 0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  p4;

    logic        iv8 = 0, ir8, ov8, or8 = 0, sgn8 = 0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_mult_nb #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .sgn(sgn4), .out_valid(ov4), .out_ready(or4), .prod(p4)
    );

    seq_mult_nb #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .sgn(sgn8), .out_valid(ov8), .out_ready(or8), .prod(p8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Operand value as an integer under the chosen signedness.
    function automatic int ext(input logic [7:0] v, input int w, input logic s);
        int r;
        r = int'(v);
        if (s && v[w-1]) r = r - (1 << w);
        return r;
    endfunction

    // Model: one pending product, ready for output after W cycles.
    logic        m4_pend = 0, m8_pend = 0;
    int          m4_left = 0, m8_left = 0;
    logic [7:0]  m4_exp = '0;
    logic [15:0] m8_exp = '0;
    int          m8_nacc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4_pend <= 0;
            m4_left <= 0;
            m8_pend <= 0;
            m8_left <= 0;
        end else begin
            if (m4_pend) begin
                if (m4_left == 0) begin
                    if (or4) m4_pend <= 0;
                end else m4_left <= m4_left - 1;
            end else if (iv4) begin
                m4_pend <= 1;
                m4_left <= 4;
                m4_exp  <= 8'(ext({4'b0, a4}, 4, sgn4) * ext({4'b0, b4}, 4, sgn4));
            end
            if (m8_pend) begin
                if (m8_left == 0) begin
                    if (or8) m8_pend <= 0;
                end else m8_left <= m8_left - 1;
            end else if (iv8) begin
                m8_pend <= 1;
                m8_left <= 8;
                m8_exp  <= 16'(ext(a8, 8, sgn8) * ext(b8, 8, sgn8));
                m8_nacc <= m8_nacc + 1;
            end
        end
    end

    // Compare process: every falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ov4", 32'(ov4), 32'd0);
            chk("rst_ir4", 32'(ir4), 32'd1);
            chk("rst_p4",  32'(p4),  32'd0);
            chk("rst_ov8", 32'(ov8), 32'd0);
            chk("rst_p8",  32'(p8),  32'd0);
        end else begin
            chk("ov4", 32'(ov4), 32'(m4_pend && m4_left == 0));
            chk("ir4", 32'(ir4), 32'(!m4_pend));
            if (m4_pend && m4_left == 0) chk("p4", 32'(p4), 32'(m4_exp));
            chk("ov8", 32'(ov8), 32'(m8_pend && m8_left == 0));
            chk("ir8", 32'(ir8), 32'(!m8_pend));
            if (m8_pend && m8_left == 0) chk("p8", 32'(p8), 32'(m8_exp));
        end
    end

    // Entered and left #1 after a rising edge with the W4 DUT idle.
    task automatic do4(input logic [3:0] a, input logic [3:0] b, input logic s,
                       input logic [7:0] exp, input int hold);
        int n;
        a4 = a; b4 = b; sgn4 = s; iv4 = 1;
        @(posedge clk); #1;
        iv4 = 0;
        n = 0;
        while (!ov4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("lat4", 32'(n), 32'd4);
        chk("prod4", 32'(p4), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            iv4 = (h % 2 == 0); a4 = 4'd3; b4 = 4'd3;
            @(posedge clk); #1;
            iv4 = 0;
            chk("hold_ov4", 32'(ov4), 32'd1);
            chk("hold_ir4", 32'(ir4), 32'd0);
            chk("hold_p4",  32'(p4),  32'(exp));
        end
        or4 = 1;
        @(posedge clk); #1;
        or4 = 0;
        chk("take_ir4", 32'(ir4), 32'd1);
        chk("take_ov4", 32'(ov4), 32'd0);
    endtask

    task automatic do8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp);
        int n;
        a8 = a; b8 = b; sgn8 = s; iv8 = 1;
        @(posedge clk); #1;
        iv8 = 0;
        n = 0;
        while (!ov8 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("lat8", 32'(n), 32'd8);
        chk("prod8", 32'(p8), 32'(exp));
        or8 = 1;
        @(posedge clk); #1;
        or8 = 0;
    endtask

    initial begin
        int c;
        repeat (2) @(posedge clk);
        #1;
        chk("init_ir4", 32'(ir4), 32'd1);
        chk("init_ov4", 32'(ov4), 32'd0);
        chk("init_p4",  32'(p4),  32'd0);
        rst_n = 1;
        @(posedge clk); #1;

        do4(4'hF, 4'hF, 1'b0, 8'hE1, 0);
        do4(4'h8, 4'h8, 1'b1, 8'h40, 0);
        do4(4'h8, 4'h7, 1'b1, 8'hC8, 0);
        do4(4'h0, 4'h9, 1'b0, 8'h00, 0);
        do4(4'hD, 4'h3, 1'b1, 8'hF7, 0);
        do4(4'hF, 4'h1, 1'b1, 8'hFF, 5);

        // Reset two BUSY edges into an operation.
        a4 = 4'h5; b4 = 4'h6; sgn4 = 0; iv4 = 1;
        @(posedge clk); #1;
        iv4 = 0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("abort_ov4", 32'(ov4), 32'd0);
        chk("abort_ir4", 32'(ir4), 32'd1);
        chk("abort_p4",  32'(p4),  32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        do4(4'h5, 4'h6, 1'b0, 8'h1E, 0);

        do8(8'h80, 8'h80, 1'b1, 16'h4000);
        do8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        do8(8'hFF, 8'hFF, 1'b1, 16'h0001);
        do8(8'h7F, 8'h80, 1'b1, 16'hC080);

        c = 0;
        while (m8_nacc < 1004 && c < 40000) begin
            iv8  = 1'($urandom_range(0, 1));
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            sgn8 = 1'($urandom_range(0, 1));
            or8  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            c++;
        end
        iv8 = 0;
        chk("rand_count", 32'(m8_nacc >= 1004), 32'd1);
        or8 = 1;
        repeat (12) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
